alu_operand_collect: RTL and testbench
======================================

ALU_OPERAND_COLLECT -- requirements
Module: alu_operand_collect

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs: in_alu_select 1, in_wfid 6, in_instr_pc 32, in_opcode 32, in_imm_value0 16, in_imm_value1 32, in_source1_addr/in_source2_addr/in_source3_addr 12 each, in_dest1_addr/in_dest2_addr 12 each. These are the registered issue-to-ALU fields.
REQ-004 SHALL have register-file read port: rf_rd_en out 1; rf_rd_vgpr out 1 (1=VGPR, 0=SGPR); rf_rd_addr out 10; rf_rd_data in 32, returned exactly one cycle after rf_rd_en.
REQ-005 SHALL have execute handshake outputs: out_valid 1, out_wfid 6, out_instr_pc 32, out_opcode 32, out_imm_value0 16, out_dest1_addr 12, out_dest2_addr 12, out_src1_data/out_src2_data/out_src3_data 32 each. Input: out_ready 1.
REQ-006 SHALL have status outputs: out_busy 1 (issue must not select); out_overrun 1 (one-cycle pulse).

Function
REQ-007 Source address decode SHALL use [11:10]: 00 none -> data 0; 01 SGPR, addr [8:0]; 10 VGPR, addr [9:0]; 11 immediate -> in_imm_value1.
REQ-008 FSM states SHALL be IDLE, ISSUE, CAPTURE, OUT, with a 2-bit operand index idx (0..2).
REQ-009 IDLE: on an edge with in_alu_select=1, SHALL latch all in_* fields, set idx=0, and go to ISSUE.
REQ-010 ISSUE, register operand: SHALL drive rf_rd_en=1 with rf_rd_vgpr/rf_rd_addr for operand idx, then go to CAPTURE.
REQ-011 ISSUE, none/immediate operand: SHALL write the slot directly and keep rf_rd_en=0; if idx<2, increment idx and stay in ISSUE, else go to OUT.
REQ-012 CAPTURE: SHALL latch rf_rd_data into slot idx; if idx<2, increment idx and go to ISSUE, else go to OUT.
REQ-013 Latency: out_valid SHALL rise 3+R cycles after the accept edge, where R is the number of register operands (range 3..6).
REQ-014 OUT: SHALL hold out_valid=1 with all outputs stable until an edge with out_ready=1; then go to IDLE.
REQ-015 out_busy SHALL equal (state!=IDLE) && !(state==OUT && out_ready).
REQ-016 Back-to-back: if in_alu_select=1 on the handshake edge in OUT, the block SHALL accept the new instruction and go directly to ISSUE.
REQ-017 If in_alu_select=1 on an edge while out_busy=1, the instruction SHALL be dropped, state SHALL be unchanged, and out_overrun SHALL pulse high for the next cycle.
REQ-018 rf_rd_en SHALL be high only in ISSUE for a register operand, never for two consecutive cycles.
REQ-019 Source slots SHALL be filled strictly in order 1, 2, 3.

Reset
REQ-020 While rst=0 (asynchronous, no clock required): state=IDLE, idx=0, all outputs and latched fields 0 (out_valid, out_busy, out_overrun, rf_rd_en all 0).
REQ-021 Reset asserted mid-operation SHALL abandon the instruction; rf_rd_en SHALL drop immediately; no out_valid SHALL follow deassertion.
REQ-022 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-023 src1=0x801 (VGPR 1), src2=0x405 (SGPR 5), src3=0x000, RF returns 0xAAAA0001 / 0x55550005; out_ready=1 -> out_valid 5 cycles after accept; src1=0xAAAA0001, src2=0x55550005, src3=0; two rf_rd_en pulses with vgpr=1,addr=1 then vgpr=0,addr=5.
REQ-024 All three sources=0xC00, imm_value1=0xDEADBEEF -> no rf_rd_en; out_valid at accept+3; all three src data=0xDEADBEEF.
REQ-025 out_ready held 0 for 4 cycles in OUT -> out_valid and all outputs stable; out_busy=1; handshake on the 5th edge -> IDLE.
REQ-026 In OUT with out_ready=1 and in_alu_select=1 on the same edge -> new instruction accepted, out_valid low next cycle, no out_overrun.
REQ-027 in_alu_select=1 during CAPTURE -> out_overrun=1 for exactly one cycle; the original instruction completes with unchanged data.
REQ-028 rst=0 during CAPTURE of src2 -> rf_rd_en and all outputs 0 immediately; after release, out_valid stays 0 with no selects issued.

Source files
------------

// File: rtl/alu_operand_collect.sv
// Operand collector between issue and the ALU: latches an issued instruction, fetches up to
// three source operands (register file, immediate or none) in order, then presents them.
module alu_operand_collect (
  input  logic        clk,
  input  logic        rst,

  input  logic        in_alu_select,
  input  logic [5:0]  in_wfid,
  input  logic [31:0] in_instr_pc,
  input  logic [31:0] in_opcode,
  input  logic [15:0] in_imm_value0,
  input  logic [31:0] in_imm_value1,
  input  logic [11:0] in_source1_addr,
  input  logic [11:0] in_source2_addr,
  input  logic [11:0] in_source3_addr,
  input  logic [11:0] in_dest1_addr,
  input  logic [11:0] in_dest2_addr,

  output logic        rf_rd_en,
  output logic        rf_rd_vgpr,
  output logic [9:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,

  output logic        out_valid,
  output logic [5:0]  out_wfid,
  output logic [31:0] out_instr_pc,
  output logic [31:0] out_opcode,
  output logic [15:0] out_imm_value0,
  output logic [11:0] out_dest1_addr,
  output logic [11:0] out_dest2_addr,
  output logic [31:0] out_src1_data,
  output logic [31:0] out_src2_data,
  output logic [31:0] out_src3_data,
  input  logic        out_ready,

  output logic        out_busy,
  output logic        out_overrun
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StOut} state_e;

  localparam logic [1:0] SrcNone = 2'b00;
  localparam logic [1:0] SrcSgpr = 2'b01;
  localparam logic [1:0] SrcVgpr = 2'b10;
  localparam logic [1:0] SrcImm  = 2'b11;

  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;

  logic [5:0]        wfid_q, wfid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       opcode_q, opcode_d;
  logic [15:0]       imm0_q, imm0_d;
  logic [31:0]       imm1_q, imm1_d;
  logic [11:0]       dest1_q, dest1_d;
  logic [11:0]       dest2_q, dest2_d;
  logic [2:0][11:0]  src_addr_q, src_addr_d;
  logic [2:0][31:0]  slot_q, slot_d;
  logic              overrun_q, overrun_d;

  logic [11:0] cur_addr;
  logic [1:0]  cur_kind;
  logic        cur_is_reg;
  logic        accept;
  logic        slot_we;
  logic [31:0] slot_wdata;

  // Operand currently being collected.
  always_comb begin
    case (idx_q)
      2'd0:    cur_addr = src_addr_q[0];
      2'd1:    cur_addr = src_addr_q[1];
      default: cur_addr = src_addr_q[2];
    endcase
  end

  assign cur_kind   = cur_addr[11:10];
  assign cur_is_reg = (cur_kind == SrcSgpr) || (cur_kind == SrcVgpr);

  // A select is taken only when the block is not busy; otherwise it is dropped.
  assign accept    = in_alu_select && !out_busy;
  assign overrun_d = in_alu_select && out_busy;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_alu_select) begin
          state_d = StIssue;
          idx_d   = 2'd0;
        end
      end
      StIssue: begin
        if (cur_is_reg) begin
          state_d = StCapture;
        end else if (idx_q != 2'd2) begin
          idx_d = idx_q + 2'd1;
        end else begin
          state_d = StOut;
        end
      end
      StCapture: begin
        if (idx_q != 2'd2) begin
          idx_d   = idx_q + 2'd1;
          state_d = StIssue;
        end else begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (in_alu_select) begin
            state_d = StIssue;
            idx_d   = 2'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 2'd0;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid  = (state_q == StOut);
    out_busy   = (state_q != StIdle) && !((state_q == StOut) && out_ready);
    rf_rd_en   = (state_q == StIssue) && cur_is_reg;
    rf_rd_vgpr = 1'b0;
    rf_rd_addr = 10'd0;
    if (rf_rd_en) begin
      rf_rd_vgpr = (cur_kind == SrcVgpr);
      // SGPR space is only 9 bits wide; bit 9 of the source field is ignored.
      rf_rd_addr = (cur_kind == SrcVgpr) ? cur_addr[9:0] : {1'b0, cur_addr[8:0]};
    end
  end

  // Slot write source: direct fill in ISSUE for none/immediate, register data in CAPTURE.
  always_comb begin
    slot_we    = 1'b0;
    slot_wdata = 32'd0;
    if (state_q == StIssue && !cur_is_reg) begin
      slot_we    = 1'b1;
      slot_wdata = (cur_kind == SrcImm) ? imm1_q : 32'd0;
    end else if (state_q == StCapture) begin
      slot_we    = 1'b1;
      slot_wdata = rf_rd_data;
    end
  end

  // Datapath next-state.
  always_comb begin
    wfid_d     = wfid_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    imm0_d     = imm0_q;
    imm1_d     = imm1_q;
    dest1_d    = dest1_q;
    dest2_d    = dest2_q;
    src_addr_d = src_addr_q;
    slot_d     = slot_q;
    if (accept) begin
      wfid_d        = in_wfid;
      pc_d          = in_instr_pc;
      opcode_d      = in_opcode;
      imm0_d        = in_imm_value0;
      imm1_d        = in_imm_value1;
      dest1_d       = in_dest1_addr;
      dest2_d       = in_dest2_addr;
      src_addr_d[0] = in_source1_addr;
      src_addr_d[1] = in_source2_addr;
      src_addr_d[2] = in_source3_addr;
      slot_d        = '0;
    end else if (slot_we) begin
      for (int k = 0; k < 3; k++) begin
        if (idx_q == k[1:0]) begin
          slot_d[k] = slot_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wfid_q     <= '0;
      pc_q       <= '0;
      opcode_q   <= '0;
      imm0_q     <= '0;
      imm1_q     <= '0;
      dest1_q    <= '0;
      dest2_q    <= '0;
      src_addr_q <= '0;
      slot_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      wfid_q     <= wfid_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      imm0_q     <= imm0_d;
      imm1_q     <= imm1_d;
      dest1_q    <= dest1_d;
      dest2_q    <= dest2_d;
      src_addr_q <= src_addr_d;
      slot_q     <= slot_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_wfid       = wfid_q;
  assign out_instr_pc   = pc_q;
  assign out_opcode     = opcode_q;
  assign out_imm_value0 = imm0_q;
  assign out_dest1_addr = dest1_q;
  assign out_dest2_addr = dest2_q;
  assign out_src1_data  = slot_q[0];
  assign out_src2_data  = slot_q[1];
  assign out_src3_data  = slot_q[2];
  assign out_overrun    = overrun_q;

endmodule

// File: tb/tb_alu_operand_collect.sv
// Directed bench for alu_operand_collect: table of operand mixes plus hand-written
// back-to-back, overrun and mid-operation reset sequences.
module tb_alu_operand_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_alu_select;
  logic [5:0]  in_wfid;
  logic [31:0] in_instr_pc, in_opcode, in_imm_value1;
  logic [15:0] in_imm_value0;
  logic [11:0] in_source1_addr, in_source2_addr, in_source3_addr;
  logic [11:0] in_dest1_addr, in_dest2_addr;
  logic        rf_rd_en, rf_rd_vgpr;
  logic [9:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid, out_ready, out_busy, out_overrun;
  logic [5:0]  out_wfid;
  logic [31:0] out_instr_pc, out_opcode;
  logic [15:0] out_imm_value0;
  logic [11:0] out_dest1_addr, out_dest2_addr;
  logic [31:0] out_src1_data, out_src2_data, out_src3_data;

  alu_operand_collect dut (
    .clk(clk), .rst(rst),
    .in_alu_select(in_alu_select), .in_wfid(in_wfid), .in_instr_pc(in_instr_pc),
    .in_opcode(in_opcode), .in_imm_value0(in_imm_value0), .in_imm_value1(in_imm_value1),
    .in_source1_addr(in_source1_addr), .in_source2_addr(in_source2_addr),
    .in_source3_addr(in_source3_addr), .in_dest1_addr(in_dest1_addr),
    .in_dest2_addr(in_dest2_addr),
    .rf_rd_en(rf_rd_en), .rf_rd_vgpr(rf_rd_vgpr), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_wfid(out_wfid), .out_instr_pc(out_instr_pc),
    .out_opcode(out_opcode), .out_imm_value0(out_imm_value0),
    .out_dest1_addr(out_dest1_addr), .out_dest2_addr(out_dest2_addr),
    .out_src1_data(out_src1_data), .out_src2_data(out_src2_data),
    .out_src3_data(out_src3_data), .out_ready(out_ready),
    .out_busy(out_busy), .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] s1, s2, s3;
    logic [31:0] imm;
    logic [31:0] e1, e2, e3;
    int          lat;
    int          nrd;
    logic [10:0] first_rd, last_rd;  // {vgpr, addr}
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail = 0;

  int          rd_cnt = 0;
  int          rd_consec = 0;
  logic        rd_prev = 1'b0;
  logic [10:0] rd_first, rd_last;

  // Register-file model: data encodes which file and address were read.
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= {rf_rd_vgpr ? 16'hAAAA : 16'h5555, 6'd0, rf_rd_addr};
  end

  always @(negedge clk) begin
    if (rf_rd_en) begin
      if (rd_cnt == 0) rd_first = {rf_rd_vgpr, rf_rd_addr};
      rd_last = {rf_rd_vgpr, rf_rd_addr};
      rd_cnt++;
      if (rd_prev) rd_consec++;
    end
    rd_prev = rf_rd_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input logic [11:0] s1, s2, s3, input logic [31:0] imm,
                             input int tag);
    in_wfid         = 6'(tag + 3);
    in_instr_pc     = 32'h1000 + 32'(tag * 4);
    in_opcode       = 32'hA000_0000 | 32'(tag);
    in_imm_value0   = 16'h0100 + 16'(tag);
    in_imm_value1   = imm;
    in_dest1_addr   = 12'h800 | 12'(tag);
    in_dest2_addr   = 12'h400 | 12'(tag);
    in_source1_addr = s1;
    in_source2_addr = s2;
    in_source3_addr = s3;
  endtask

  task automatic check_fields(input string tagname, input int tag);
    chk({tagname, "_wfid"}, 32'(out_wfid), 32'(6'(tag + 3)));
    chk({tagname, "_pc"}, out_instr_pc, 32'h1000 + 32'(tag * 4));
    chk({tagname, "_opcode"}, out_opcode, 32'hA000_0000 | 32'(tag));
    chk({tagname, "_imm0"}, 32'(out_imm_value0), 32'(16'h0100 + 16'(tag)));
    chk({tagname, "_dest"}, {8'd0, out_dest1_addr, out_dest2_addr},
        {8'd0, 12'h800 | 12'(tag), 12'h400 | 12'(tag)});
  endtask

  // Present an instruction at a negedge; returns #1 after the accept edge.
  task automatic accept(input vec_t v, input int tag);
    @(negedge clk);
    drive_instr(v.s1, v.s2, v.s3, v.imm, tag);
    in_alu_select = 1'b1;
    @(posedge clk);
    #1;
    in_alu_select = 1'b0;
    rd_cnt = 0;
  endtask

  // Counts edges until out_valid is seen at a negedge, bounded at 20.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 20);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int vcnt;

    vecs[0] = '{12'h801, 12'h405, 12'h000, 32'h0, 32'hAAAA0001, 32'h55550005, 32'h0,
                5, 2, {1'b1, 10'h001}, {1'b0, 10'h005}};
    vecs[1] = '{12'hC00, 12'hC00, 12'hC00, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                32'hDEADBEEF, 3, 0, 11'h0, 11'h0};
    vecs[2] = '{12'h000, 12'h000, 12'h000, 32'h12121212, 32'h0, 32'h0, 32'h0,
                3, 0, 11'h0, 11'h0};
    vecs[3] = '{12'h9FF, 12'h7FF, 12'hC00, 32'h12345678, 32'hAAAA01FF, 32'h555501FF,
                32'h12345678, 5, 2, {1'b1, 10'h1FF}, {1'b0, 10'h1FF}};
    vecs[4] = '{12'h8AB, 12'h8CD, 12'hBFF, 32'h0, 32'hAAAA00AB, 32'hAAAA00CD,
                32'hAAAA03FF, 6, 3, {1'b1, 10'h0AB}, {1'b1, 10'h3FF}};
    vecs[5] = '{12'h401, 12'hC00, 12'h402, 32'hCAFEF00D, 32'h55550001, 32'hCAFEF00D,
                32'h55550002, 5, 2, {1'b0, 10'h001}, {1'b0, 10'h002}};

    rst = 1'b0;
    in_alu_select = 1'b0;
    out_ready = 1'b0;
    rf_rd_data = 32'd0;
    drive_instr(12'h0, 12'h0, 12'h0, 32'h0, 0);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(out_busy), 32'd0);
    chk("reset_overrun", 32'(out_overrun), 32'd0);
    chk("reset_rd_en", 32'(rf_rd_en), 32'd0);
    chk("reset_src1", out_src1_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i], i);
      wait_valid(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d_src1", i), out_src1_data, vecs[i].e1);
      chk($sformatf("v%0d_src2", i), out_src2_data, vecs[i].e2);
      chk($sformatf("v%0d_src3", i), out_src3_data, vecs[i].e3);
      chk($sformatf("v%0d_rd_count", i), 32'(rd_cnt), 32'(vecs[i].nrd));
      if (vecs[i].nrd > 0) begin
        chk($sformatf("v%0d_rd_first", i), 32'(rd_first), 32'(vecs[i].first_rd));
        chk($sformatf("v%0d_rd_last", i), 32'(rd_last), 32'(vecs[i].last_rd));
      end
      check_fields($sformatf("v%0d", i), i);
      chk($sformatf("v%0d_overrun", i), 32'(out_overrun), 32'd0);
      repeat (4) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk($sformatf("v%0d_stall_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_stall_busy", i), 32'(out_busy), 32'd1);
      chk($sformatf("v%0d_stall_src1", i), out_src1_data, vecs[i].e1);
      chk($sformatf("v%0d_stall_src3", i), out_src3_data, vecs[i].e3);
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ready_busy", i), 32'(out_busy), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_valid", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back: new select on the handshake edge.
    accept(vecs[1], 10);
    wait_valid(n);
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    drive_instr(12'hC00, 12'hC00, 12'hC00, 32'h11112222, 11);
    in_alu_select = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_alu_select = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_valid_low", 32'(out_valid), 32'd0);
    chk("b2b_no_overrun", 32'(out_overrun), 32'd0);
    chk("b2b_busy", 32'(out_busy), 32'd1);
    wait_valid(n);
    chk("b2b_latency", 32'(n), 32'd3);
    chk("b2b_src1", out_src1_data, 32'h11112222);
    check_fields("b2b", 11);
    handshake();

    // Overrun: select during CAPTURE of src1 is dropped.
    accept(vecs[0], 20);
    @(posedge clk);
    @(negedge clk);
    drive_instr(12'hC00, 12'hC00, 12'hC00, 32'hFFFFFFFF, 30);
    in_alu_select = 1'b1;
    @(posedge clk);
    #1;
    in_alu_select = 1'b0;
    @(negedge clk);
    chk("ovr_pulse", 32'(out_overrun), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("ovr_pulse_end", 32'(out_overrun), 32'd0);
    wait_valid(n);
    chk("ovr_remaining_latency", 32'(n), 32'd2);
    chk("ovr_src1", out_src1_data, 32'hAAAA0001);
    chk("ovr_src2", out_src2_data, 32'h55550005);
    chk("ovr_src3", out_src3_data, 32'h0);
    check_fields("ovr", 20);
    handshake();

    // Reset during CAPTURE of src2.
    accept(vecs[0], 40);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_rd_en", 32'(rf_rd_en), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd_en", 32'(rf_rd_en), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_src1", out_src1_data, 32'd0);
    chk("rst_wfid", 32'(out_wfid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_cnt = 0;
    vcnt = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("rst_no_valid", 32'(vcnt), 32'd0);
    chk("rst_no_rd", 32'(rd_cnt), 32'd0);

    // First accept on the first edge after reset release.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_instr(vecs[1].s1, vecs[1].s2, vecs[1].s3, vecs[1].imm, 50);
    in_alu_select = 1'b1;
    @(posedge clk);
    #1;
    in_alu_select = 1'b0;
    wait_valid(n);
    chk("post_rst_latency", 32'(n), 32'd3);
    chk("post_rst_src2", out_src2_data, 32'hDEADBEEF);
    handshake();

    chk("rd_en_consecutive", 32'(rd_consec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
